// File: rtl/wb_sram_banked.sv
// Wishbone classic slave over BANKS 1024x32 SRAM banks with a one-shot ack FSM,
// optional registered read data and err_o for unpopulated banks.
module wb_sram_banked #(
  parameter int BANKS     = 2,
  parameter int OUT_REG   = 0,
  parameter int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [9+BANK_BITS:0] adr_i,
  input  logic [31:0]          dat_i,
  output logic [31:0]          dat_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam int                 NSLOT   = 1 << BANK_BITS;
  localparam logic [BANK_BITS:0] BANKS_W = BANKS[BANK_BITS:0];

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RESP = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [BANK_BITS-1:0] bank_s, bank_q, bank_d;
  logic                 ack_q, ack_d, err_q, err_d;
  logic                 req_s, in_range_s;
  logic [31:0]          ben_s, rdata_s;
  logic [31:0]          do_s [NSLOT];

  assign bank_s     = adr_i[9+BANK_BITS:10];
  assign in_range_s = ({1'b0, bank_s} < BANKS_W);
  // Gating with rst_i keeps every macro disabled while reset is held.
  assign req_s      = cyc_i & stb_i & (state_q == IDLE) & ~rst_i;
  assign ben_s      = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign rdata_s    = do_s[bank_q];

  for (genvar g = 0; g < NSLOT; g++) begin : g_bank
    if (g < BANKS) begin : g_mac
      // Behavioural equivalent of one EF_SRAM_1024x32_wrapper: sync read, byte-masked write.
      logic        en_s;
      logic [31:0] mem_q [1024];
      logic [31:0] do_q;

      assign en_s = req_s & (bank_s == BANK_BITS'(g));

      always_ff @(posedge clk_i) begin
        if (en_s) begin
          if (we_i) begin
            mem_q[adr_i[9:0]] <= (mem_q[adr_i[9:0]] & ~ben_s) | (dat_i & ben_s);
          end else begin
            do_q <= mem_q[adr_i[9:0]];
          end
        end
      end

      assign do_s[g] = do_q;
    end else begin : g_empty
      assign do_s[g] = 32'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (in_range_s) begin
            bank_d = bank_s;
            if (we_i || (OUT_REG == 0)) begin
              state_d = RESP;
              ack_d   = 1'b1;
            end else begin
              state_d = RD;
            end
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (cyc_i) begin
          state_d = RESP;
          ack_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bank_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [31:0] dat_q, dat_d;

    always_comb begin
      dat_d = dat_q;
      if ((state_q == RD) && cyc_i) begin
        dat_d = rdata_s;
      end else if (err_d) begin
        dat_d = 32'd0;
      end else begin
        dat_d = dat_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        dat_q <= 32'd0;
      end else begin
        dat_q <= dat_d;
      end
    end

    assign dat_o = dat_q;
  end else begin : g_comb
    assign dat_o = ack_q ? rdata_s : 32'd0;
  end

  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_sram_banked.sv
// Scoreboard bench: three instances (2 banks comb, 2 banks OUT_REG, 3 banks comb)
// share one bus; each gets its own cyc so only one is addressed at a time.
module tb_wb_sram_banked;

  typedef struct {
    int          dut;
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc_w;
  logic        stb_b, we_b;
  logic [3:0]  be_b;
  logic [11:0] adr_b;
  logic [31:0] wdat_b;
  logic [2:0]  ack_w, err_w;
  logic [31:0] dat_w [3];

  int   tests = 0;
  int   fails = 0;
  int   cnt   = 0;
  int   n_resp [3] = '{0, 0, 0};
  logic prev_rsp [3] = '{1'b0, 1'b0, 1'b0};
  exp_t exp_q [$];
  exp_t mon_e;
  int   base, r0, r1;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  wb_sram_banked #(.BANKS(2), .OUT_REG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_w[0]), .stb_i(stb_b), .we_i(we_b), .be_i(be_b),
    .adr_i(adr_b[10:0]), .dat_i(wdat_b), .dat_o(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]));

  wb_sram_banked #(.BANKS(2), .OUT_REG(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_w[1]), .stb_i(stb_b), .we_i(we_b), .be_i(be_b),
    .adr_i(adr_b[10:0]), .dat_i(wdat_b), .dat_o(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]));

  wb_sram_banked #(.BANKS(3), .OUT_REG(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_w[2]), .stb_i(stb_b), .we_i(we_b), .be_i(be_b),
    .adr_i(adr_b), .dat_i(wdat_b), .dat_o(dat_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack/err pops one expectation and checks dut, kind, cycle and data.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack_w[k] || err_w[k]) begin
        n_resp[k]++;
        chk("single_pulse", {31'd0, prev_rsp[k]}, 32'd0);
        chk("ack_err_excl", {31'd0, ack_w[k] & err_w[k]}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: dut%0d ack=%b err=%b, required none", k, ack_w[k], err_w[k]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_dut", 32'(k), 32'(mon_e.dut));
          chk("rsp_kind_err", {31'd0, err_w[k]}, {31'd0, mon_e.err});
          chk("rsp_cycle", 32'(cnt), 32'(mon_e.due));
          if (mon_e.chk) chk("rsp_data", dat_w[k], mon_e.data);
        end
      end
      prev_rsp[k] = ack_w[k] | err_w[k];
    end
  end

  task automatic xfer(input int k, input logic we, input logic [11:0] adr, input logic [31:0] wd,
                      input logic [3:0] be, input logic is_err, input logic [31:0] exp_d,
                      input logic chk_d, input int lat);
    exp_t e;
    bit   got;
    adr_b    = adr;
    wdat_b   = wd;
    we_b     = we;
    be_b     = be;
    cyc_w[k] = 1'b1;
    stb_b    = 1'b1;
    e = '{k, is_err, chk_d, exp_d, cnt + lat};
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_w[k] || err_w[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL timeout: dut%0d adr %h no ack/err, required one", k, adr);
      void'(exp_q.pop_back());
    end
    cyc_w[k] = 1'b0;
    stb_b    = 1'b0;
    we_b     = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc_w = 3'b000; stb_b = 1'b0; we_b = 1'b0;
    be_b = 4'h0; adr_b = 12'h000; wdat_b = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", {31'd0, ack_w[k]}, 32'd0);
      chk("reset_err", {31'd0, err_w[k]}, 32'd0);
      chk("reset_dat", dat_w[k], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // dut0: basic write/read, byte lanes, zero byte-enable, bank isolation
    xfer(0, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1);
    xfer(0, 1'b1, 12'h010, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b1, 12'h010, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 1'b0, 32'h11BB33DD, 1'b1, 1);
    xfer(0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1, 1);
    xfer(0, 1'b1, 12'h3FF, 32'h00000001, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b1, 12'h7FF, 32'h00000002, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b0, 12'h3FF, 32'h0, 4'hF, 1'b0, 32'h00000001, 1'b1, 1);
    xfer(0, 1'b0, 12'h7FF, 32'h0, 4'hF, 1'b0, 32'h00000002, 1'b1, 1);

    // dut0: strobe held six cycles -> acks at +1, +3, +5 only
    base = cnt;
    r0   = n_resp[0];
    adr_b = 12'h005; we_b = 1'b0; be_b = 4'hF; cyc_w[0] = 1'b1; stb_b = 1'b1;
    exp_q.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF, base + 1});
    exp_q.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF, base + 3});
    exp_q.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF, base + 5});
    repeat (6) @(negedge clk);
    cyc_w[0] = 1'b0; stb_b = 1'b0;
    @(negedge clk);
    chk("held_ack_count", 32'(n_resp[0] - r0), 32'd3);

    // dut1: registered read adds one cycle
    xfer(1, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(1, 1'b0, 12'h005, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b1, 2);

    // dut1: abort in RD -> no ack, dat_o keeps last read word
    r1 = n_resp[1];
    adr_b = 12'h005; we_b = 1'b0; cyc_w[1] = 1'b1; stb_b = 1'b1;
    @(negedge clk);
    cyc_w[1] = 1'b0; stb_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", 32'(n_resp[1] - r1), 32'd0);
    chk("abort_dat_kept", dat_w[1], 32'hDEADBEEF);
    xfer(1, 1'b0, 12'h005, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b1, 2);

    // dut1: async reset in RD clears outputs before any clock edge
    r1 = n_resp[1];
    adr_b = 12'h005; we_b = 1'b0; cyc_w[1] = 1'b1; stb_b = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ack", {31'd0, ack_w[1]}, 32'd0);
    chk("rst_mid_dat", dat_w[1], 32'd0);
    cyc_w[1] = 1'b0; stb_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_ack", 32'(n_resp[1] - r1), 32'd0);
    xfer(1, 1'b0, 12'h005, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b1, 2);

    // dut2: three banks, bank 3 unpopulated
    xfer(2, 1'b1, 12'h000, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(2, 1'b1, 12'h800, 32'h22222222, 4'hF, 1'b0, 32'h0, 1'b0, 1);
    xfer(2, 1'b0, 12'h800, 32'h0, 4'hF, 1'b0, 32'h22222222, 1'b1, 1);
    xfer(2, 1'b1, 12'hC00, 32'h55555555, 4'hF, 1'b1, 32'h0, 1'b1, 1);
    xfer(2, 1'b0, 12'hC00, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1);
    xfer(2, 1'b0, 12'h000, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, 1'b1, 1);
    xfer(2, 1'b0, 12'h800, 32'h0, 4'hF, 1'b0, 32'h22222222, 1'b1, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
